// File: rtl/ifetch32_pkg.sv
// Shared widths, constants, FSM encoding and branch-target helper for the
// ifetch32 instruction fetch stage.
package ifetch32_pkg;

  localparam int FULLW        = 32;
  localparam int BRANCH_SHIFT = 2;
  localparam logic [FULLW-1:0] NOP_I = 32'hF000_0000;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_e;

  // Target is relative to the ARM-visible PC (word address + 8), word aligned.
  function automatic logic [FULLW-1:0] branch_target(input logic [FULLW-1:0] pc,
                                                     input logic [FULLW-1:0] off);
    logic [FULLW-1:0] t;
    t = pc + FULLW'(8) + off;
    t[BRANCH_SHIFT-1:0] = '0;
    return t;
  endfunction

endpackage

// File: rtl/ifetch32_skid.sv
// One-entry skid buffer: catches the word returning from memory while decode
// is held by a downstream stall.
module fetch_skid
  import ifetch32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             flush,
  input  logic [FULLW-1:0] d_i,
  input  logic [FULLW-1:0] d_pc,
  output logic             valid,
  output logic [FULLW-1:0] q_i,
  output logic [FULLW-1:0] q_pc
);

  logic             valid_q, valid_d;
  logic [FULLW-1:0] i_q, i_d;
  logic [FULLW-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    i_d     = i_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      i_d     = d_i;
      pc_d    = d_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      i_q     <= NOP_I;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      i_q     <= i_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign q_i   = i_q;
  assign q_pc  = pc_q;

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch stage: PC generation, synchronous imem requests, decode
// register with one-entry skid, and branch redirect with wrong-path squash.
module ifetch32
  import ifetch32_pkg::*;
#(
  parameter logic [FULLW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [FULLW-1:0] imem_addr_out,
  output logic             imem_rd_out,
  input  logic [FULLW-1:0] imem_data_in,
  input  logic             stall_in,
  input  logic             ib_in,
  input  logic [FULLW-1:0] bv_in,
  input  logic             bl_in,
  output logic [FULLW-1:0] i_out,
  output logic             i_valid_out,
  output logic [FULLW-1:0] pc_out,
  output logic [FULLW-1:0] link_addr_out
);

  fetch_state_e     state_q, state_d;
  logic [FULLW-1:0] fetch_pc_q, fetch_pc_d;
  logic             f_valid_q, f_valid_d;
  logic [FULLW-1:0] f_pc_q, f_pc_d;
  logic [FULLW-1:0] dec_i_q, dec_i_d;
  logic [FULLW-1:0] dec_pc_q, dec_pc_d;
  logic             dec_v_q, dec_v_d;

  logic             issue, redirect;
  logic             skid_load, skid_drain, skid_flush;
  logic             skid_valid;
  logic [FULLW-1:0] skid_i, skid_pc;

  // The link value is always driven; bl_in carries no extra behaviour here.
  logic unused_bl;
  assign unused_bl = bl_in;

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .flush (skid_flush),
    .d_i   (imem_data_in),
    .d_pc  (f_pc_q),
    .valid (skid_valid),
    .q_i   (skid_i),
    .q_pc  (skid_pc)
  );

  // A branch is only honoured once the branch word is actually leaving decode.
  assign redirect = ib_in && dec_v_q && !stall_in;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    dec_i_d    = dec_i_q;
    dec_pc_d   = dec_pc_q;
    dec_v_d    = dec_v_q;
    issue      = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = 1'b0;

    case (state_q)
      S_RUN, S_HOLD: begin
        if (redirect) begin
          state_d    = S_REDIR;
          fetch_pc_d = branch_target(dec_pc_q, bv_in);
          skid_flush = 1'b1;
          dec_v_d    = 1'b0;
          dec_i_d    = NOP_I;
        end else if (stall_in) begin
          if (f_valid_q) begin
            if (dec_v_q) begin
              skid_load = 1'b1;
            end else begin
              dec_v_d  = 1'b1;
              dec_i_d  = imem_data_in;
              dec_pc_d = f_pc_q;
            end
          end
          if (dec_v_q || f_valid_q) state_d = S_HOLD;
        end else begin
          issue   = 1'b1;
          state_d = S_RUN;
          if (skid_valid) begin
            skid_drain = 1'b1;
            dec_v_d    = 1'b1;
            dec_i_d    = skid_i;
            dec_pc_d   = skid_pc;
          end else if (f_valid_q) begin
            dec_v_d  = 1'b1;
            dec_i_d  = imem_data_in;
            dec_pc_d = f_pc_q;
          end else begin
            dec_v_d = 1'b0;
            dec_i_d = NOP_I;
          end
        end
      end
      S_REDIR: begin
        if (!stall_in) begin
          issue   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (issue) fetch_pc_d = fetch_pc_q + FULLW'(4);
    f_valid_d = issue;
    f_pc_d    = fetch_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      f_valid_q  <= 1'b0;
      f_pc_q     <= '0;
      dec_i_q    <= NOP_I;
      dec_pc_q   <= '0;
      dec_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      f_valid_q  <= f_valid_d;
      f_pc_q     <= f_pc_d;
      dec_i_q    <= dec_i_d;
      dec_pc_q   <= dec_pc_d;
      dec_v_q    <= dec_v_d;
    end
  end

  assign imem_addr_out = fetch_pc_q;
  assign imem_rd_out   = issue && !rst;
  assign i_out         = dec_i_q;
  assign i_valid_out   = dec_v_q;
  assign pc_out        = dec_pc_q;
  assign link_addr_out = dec_pc_q + FULLW'(4);

endmodule
